// File: rtl/gmii_tx_sink.sv
// GMII/MII transmit-path sink: strips preamble/SFD, assembles nibbles,
// checks length and FCS, and emits frames as an 8-bit AXI stream.
module gmii_tx_sink #(
  parameter int unsigned MIN_PREAMBLE     = 2,
  parameter int unsigned MIN_FRAME_LENGTH = 64,
  parameter bit          CHECK_FCS        = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_enable,
  input  logic       mii_select,
  input  logic [7:0] gmii_txd,
  input  logic       gmii_tx_en,
  input  logic       gmii_tx_er,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       stat_frame_good,
  output logic       stat_frame_bad,
  output logic       stat_bad_fcs,
  output logic       stat_preamble_err
);

  localparam int unsigned LEN_W       = 16;
  localparam int unsigned PCNT_W      = 8;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY_R  = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_PAYLOAD,
    ST_DROP
  } state_t;

  state_t              r_state;
  logic [PCNT_W-1:0]   r_pcnt;
  logic                r_phase;
  logic [3:0]          r_nib_lo;
  logic [7:0]          r_hold;
  logic                r_hold_valid;
  logic [LEN_W-1:0]    r_len;
  logic [31:0]         r_crc;
  logic                r_bad;

  logic [3:0]          w_nib;
  logic                w_sym_done;
  logic [7:0]          w_byte;
  logic [31:0]         w_crc_next;
  logic                w_is_pre;
  logic                w_is_sfd;
  logic [PCNT_W-1:0]   w_pre_need;
  logic                w_len_short;
  logic                w_fcs_bad;
  logic                w_partial;
  logic                w_frame_bad;

  // Reflected CRC32 over one byte, LSB first, no final inversion.
  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_R) : (c >> 1);
    end
    return c;
  endfunction

  // Symbol assembly and frame-status decode.
  always_comb begin
    w_nib       = gmii_txd[3:0];
    w_sym_done  = !mii_select || r_phase;
    w_byte      = mii_select ? {w_nib, r_nib_lo} : gmii_txd;
    w_crc_next  = crc_byte(r_crc, w_byte);
    // In MII mode the preamble is counted in nibbles; the SFD's low 0x5 nibble is included.
    w_is_pre    = mii_select ? (w_nib == 4'h5) : (gmii_txd == 8'h55);
    w_is_sfd    = mii_select ? (w_nib == 4'hD) : (gmii_txd == 8'hD5);
    w_pre_need  = mii_select ? PCNT_W'(2 * MIN_PREAMBLE + 1) : PCNT_W'(MIN_PREAMBLE);
    w_len_short = r_len < LEN_W'(MIN_FRAME_LENGTH);
    w_fcs_bad   = CHECK_FCS && (r_crc != CRC_RESIDUE);
    w_partial   = mii_select && r_phase;
    w_frame_bad = r_bad || w_len_short || w_partial || w_fcs_bad;
  end

  // Frame FSM, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state           <= ST_IDLE;
      r_pcnt            <= '0;
      r_phase           <= 1'b0;
      r_nib_lo          <= '0;
      r_hold            <= '0;
      r_hold_valid      <= 1'b0;
      r_len             <= '0;
      r_crc             <= CRC_INIT;
      r_bad             <= 1'b0;
      m_axis_tdata      <= '0;
      m_axis_tvalid     <= 1'b0;
      m_axis_tlast      <= 1'b0;
      m_axis_tuser      <= 1'b0;
      stat_frame_good   <= 1'b0;
      stat_frame_bad    <= 1'b0;
      stat_bad_fcs      <= 1'b0;
      stat_preamble_err <= 1'b0;
    end else begin
      m_axis_tvalid     <= 1'b0;
      m_axis_tlast      <= 1'b0;
      m_axis_tuser      <= 1'b0;
      stat_frame_good   <= 1'b0;
      stat_frame_bad    <= 1'b0;
      stat_bad_fcs      <= 1'b0;
      stat_preamble_err <= 1'b0;
      if (clk_enable) begin
        if (!gmii_tx_en) begin
          r_phase <= 1'b0;
        end
        case (r_state)
          ST_IDLE, ST_PREAMBLE: begin
            if (!gmii_tx_en) begin
              if (r_state == ST_PREAMBLE) begin
                stat_preamble_err <= 1'b1;
              end
              r_state <= ST_IDLE;
              r_pcnt  <= '0;
            end else if (w_is_pre) begin
              r_state <= ST_PREAMBLE;
              if (r_pcnt != '1) begin
                r_pcnt <= r_pcnt + PCNT_W'(1);
              end
            end else if (w_is_sfd && (r_pcnt >= w_pre_need)) begin
              r_state      <= ST_PAYLOAD;
              r_pcnt       <= '0;
              r_phase      <= 1'b0;
              r_hold_valid <= 1'b0;
              r_len        <= '0;
              r_crc        <= CRC_INIT;
              r_bad        <= 1'b0;
            end else begin
              r_state           <= ST_DROP;
              r_pcnt            <= '0;
              stat_preamble_err <= 1'b1;
            end
          end
          ST_PAYLOAD: begin
            if (gmii_tx_en) begin
              if (gmii_tx_er) begin
                r_bad <= 1'b1;
              end
              if (w_sym_done) begin
                // Release the previous byte once its successor proves it is not last.
                if (r_hold_valid) begin
                  m_axis_tdata  <= r_hold;
                  m_axis_tvalid <= 1'b1;
                end
                r_hold       <= w_byte;
                r_hold_valid <= 1'b1;
                r_crc        <= w_crc_next;
                r_phase      <= 1'b0;
                if (r_len != '1) begin
                  r_len <= r_len + LEN_W'(1);
                end
              end else begin
                r_nib_lo <= w_nib;
                r_phase  <= 1'b1;
              end
            end else begin
              if (r_hold_valid) begin
                m_axis_tdata    <= r_hold;
                m_axis_tvalid   <= 1'b1;
                m_axis_tlast    <= 1'b1;
                m_axis_tuser    <= w_frame_bad;
                stat_frame_good <= !w_frame_bad;
                stat_frame_bad  <= w_frame_bad;
                stat_bad_fcs    <= w_fcs_bad;
              end else begin
                stat_frame_bad <= 1'b1;
              end
              r_state      <= ST_IDLE;
              r_pcnt       <= '0;
              r_hold_valid <= 1'b0;
              r_len        <= '0;
              r_crc        <= CRC_INIT;
              r_bad        <= 1'b0;
            end
          end
          ST_DROP: begin
            if (!gmii_tx_en) begin
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gmii_tx_sink.sv
// Scoreboard bench for gmii_tx_sink: frames are generated with a computed FCS,
// expected beats are queued at drive time and compared as the stream appears.
module tb_gmii_tx_sink;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk_enable;
  logic       mii_select;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en;
  logic       gmii_tx_er;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tlast;
  logic       m_axis_tuser;
  logic       stat_frame_good;
  logic       stat_frame_bad;
  logic       stat_bad_fcs;
  logic       stat_preamble_err;

  gmii_tx_sink dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .clk_enable        (clk_enable),
    .mii_select        (mii_select),
    .gmii_txd          (gmii_txd),
    .gmii_tx_en        (gmii_tx_en),
    .gmii_tx_er        (gmii_tx_er),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tuser      (m_axis_tuser),
    .stat_frame_good   (stat_frame_good),
    .stat_frame_bad    (stat_frame_bad),
    .stat_bad_fcs      (stat_bad_fcs),
    .stat_preamble_err (stat_preamble_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       last;
    logic       user;
    logic       fcs;
  } exp_t;

  exp_t sb[$];
  int   n_checks   = 0;
  int   n_errors   = 0;
  int   n_pre_err  = 0;
  int   n_tlast    = 0;
  int   en_div     = 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference FCS: standard reflected CRC32 with final inversion.
  function automatic logic [31:0] fcs_of(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Stream monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (stat_preamble_err) n_pre_err++;
    if (stat_frame_good && !m_axis_tlast) check_eq("stray_good", 1, 0);
    if (m_axis_tvalid) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_beat", {24'h0, m_axis_tdata}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("tdata", m_axis_tdata, e.d);
        check_eq("tlast", m_axis_tlast, e.last);
        if (e.last) begin
          n_tlast++;
          check_eq("tuser", m_axis_tuser, e.user);
          check_eq("stat_good", stat_frame_good, !e.user);
          check_eq("stat_bad", stat_frame_bad, e.user);
          check_eq("stat_bad_fcs", stat_bad_fcs, e.fcs);
        end
      end
    end
  end

  // One enabled sample, followed by en_div-1 disabled cycles carrying junk data.
  task automatic step(input logic en, input logic er, input logic [7:0] d);
    clk_enable = 1'b1;
    gmii_tx_en = en;
    gmii_tx_er = er;
    gmii_txd   = d;
    @(posedge clk); #1;
    for (int i = 1; i < en_div; i++) begin
      clk_enable = 1'b0;
      gmii_txd   = 8'($urandom);
      gmii_tx_er = 1'($urandom);
      @(posedge clk); #1;
    end
    gmii_tx_er = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic er);
    if (mii_select) begin
      step(1'b1, er, {4'($urandom), b[3:0]});
      step(1'b1, er, {4'($urandom), b[7:4]});
    end else begin
      step(1'b1, er, b);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  // n_total includes the 4 FCS bytes; rst_at >= 0 resets while that byte is driven.
  task automatic send_frame(input int n_total, input int pre_n, input int er_idx,
                            input bit flip, input bit extra_nib, input int rst_at);
    logic [7:0]  fr[$];
    logic [31:0] fcs;
    logic        bad;
    exp_t        e;
    for (int i = 0; i < n_total - 4; i++) fr.push_back(8'(i));
    fcs = fcs_of(fr);
    fr.push_back(fcs[7:0]);
    fr.push_back(fcs[15:8]);
    fr.push_back(fcs[23:16]);
    fr.push_back(fcs[31:24]);
    if (flip) fr[n_total-4] = fr[n_total-4] ^ 8'hFF;
    bad = (er_idx >= 0) || (n_total < 64) || flip || extra_nib;
    for (int i = 0; i < pre_n; i++) send_byte(8'h55, 1'b0);
    send_byte(8'hD5, 1'b0);
    for (int k = 0; k < n_total; k++) begin
      if (rst_at >= 0 && k == rst_at) begin
        rst_n = 1'b0;
        step(1'b1, 1'b0, fr[k]);
        check_eq("rst_mid_outputs",
                 {m_axis_tvalid, m_axis_tlast, m_axis_tuser, stat_frame_good,
                  stat_frame_bad, stat_bad_fcs, stat_preamble_err}, 0);
        step(1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;
        idle(4);
        return;
      end
      if (!(rst_at >= 0 && k >= rst_at - 1)) begin
        e.d    = fr[k];
        e.last = (k == n_total - 1);
        e.user = e.last && bad;
        e.fcs  = e.last && flip;
        sb.push_back(e);
      end
      send_byte(fr[k], k == er_idx);
    end
    if (extra_nib) step(1'b1, 1'b0, {4'($urandom), 4'h3});
    idle(3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pre0;
    int fr0;
    rst_n      = 1'b0;
    clk_enable = 1'b1;
    mii_select = 1'b0;
    gmii_txd   = 8'h00;
    gmii_tx_en = 1'b0;
    gmii_tx_er = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs",
             {m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser, stat_frame_good,
              stat_frame_bad, stat_bad_fcs, stat_preamble_err}, 0);
    rst_n = 1'b1;
    idle(3);

    // GMII good frame, bad FCS, tx_er in payload
    send_frame(64, 7, -1, 1'b0, 1'b0, -1);
    send_frame(64, 7, -1, 1'b1, 1'b0, -1);
    send_frame(64, 7, 10, 1'b0, 1'b0, -1);
    check_eq("frames_gmii", n_tlast, 3);

    // Preamble errors: bad byte, then too-short preamble
    pre0 = n_pre_err;
    send_byte(8'h55, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1'b0);
    idle(3);
    check_eq("pre_err_bad_byte", n_pre_err - pre0, 1);
    pre0 = n_pre_err;
    send_byte(8'h55, 1'b0);
    send_byte(8'hD5, 1'b0);
    for (int i = 0; i < 8; i++) send_byte(8'h5A, 1'b0);
    idle(3);
    check_eq("pre_err_short", n_pre_err - pre0, 1);

    // MII with sparse enable: good frame, then one trailing nibble
    mii_select = 1'b1;
    en_div     = 10;
    send_frame(64, 7, -1, 1'b0, 1'b0, -1);
    send_frame(64, 7, -1, 1'b0, 1'b1, -1);
    check_eq("frames_mii", n_tlast, 5);
    mii_select = 1'b0;
    en_div     = 1;

    // Short frame with minimum preamble, then mid-frame reset and recovery
    send_frame(20, 2, -1, 1'b0, 1'b0, -1);
    fr0 = n_tlast;
    send_frame(64, 7, -1, 1'b0, 1'b0, 30);
    check_eq("no_tlast_after_reset", n_tlast - fr0, 0);
    check_eq("sb_empty_after_reset", sb.size(), 0);
    send_frame(64, 7, -1, 1'b0, 1'b0, -1);
    check_eq("frames_total", n_tlast, 7);
    check_eq("pre_err_total", n_pre_err, 2);

    idle(5);
    check_eq("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
